div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter LATENCY, default 28: enabled-cycle latency of the pipelined unsigned divider core, from in_valid sample to out_valid/ans.
REQ-002 Parameter TAG_W, default 5: width of the request tag.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when req_valid & req_ready.
REQ-007 req_op  in  2  bit1 = remainder (else quotient); bit0 = unsigned (else signed); equals RISC-V funct3[1:0].
REQ-008 req_a / req_b  in  32 each  dividend / divisor.
REQ-009 req_tag  in  TAG_W  opaque tag, returned with the result.
REQ-010 flush  in  1  discard all in-flight and held results.
REQ-011 resp_valid / resp_ready  out / in  1 each  result handshake.
REQ-012 resp_data / resp_tag  out  32 / TAG_W  final result and its tag.
REQ-013 div_in_valid, div_dividend[31:0], div_divisor[31:0], div_ctrl[1:0], div_stall  out  drive the divider core.
REQ-014 div_ans[31:0], div_out_valid  in  divider core result (quotient or remainder per div_ctrl[1]).
REQ-015 inflight_cnt  out  6  number of live accepted requests not yet handed off; idle  out  1  inflight_cnt==0.

Function
REQ-016 div_stall SHALL equal resp_valid & !resp_ready; req_ready SHALL equal !div_stall & !flush.
REQ-017 On acceptance, the block SHALL drive div_in_valid=1 with |req_a|, |req_b| (magnitudes when signed, raw when unsigned) and div_ctrl={req_op[1],1'b1}.
REQ-018 A metadata shift register of LATENCY slots (valid, tag, op[1], negate, special, special_value[31:0]) SHALL advance only when div_stall=0, aligned so slot 0 pairs with div_ans.
REQ-019 negate SHALL be: quotient op -> signed & (a[31]^b[31]) & b!=0; remainder op -> signed & a[31].
REQ-020 Divide-by-zero (b==0) SHALL be marked special: quotient 32'hFFFFFFFF, remainder = req_a.
REQ-021 Signed overflow (a==32'h80000000, b==32'hFFFFFFFF) SHALL be marked special: quotient 32'h80000000, remainder 0.
REQ-022 Special requests SHALL still occupy a pipeline slot so responses stay in acceptance order.
REQ-023 When slot 0 is valid and div_stall=0, the response register SHALL load resp_data = special ? special_value : (negate ? -div_ans : div_ans), resp_tag, and set resp_valid.
REQ-024 resp_valid SHALL clear on resp_ready unless a new result loads in the same cycle; sustained throughput one result per cycle.
REQ-025 Latency without stalls: resp_valid rises exactly LATENCY+1 cycles after the accepting edge.
REQ-026 resp_data/resp_tag SHALL hold stable while resp_valid & !resp_ready.
REQ-027 div_out_valid with slot 0 invalid (flushed entry) SHALL be ignored.
REQ-028 flush SHALL clear all slot valid bits and resp_valid next cycle; inflight_cnt -> 0; no request accepted that cycle.
REQ-029 inflight_cnt SHALL +1 on accept, -1 on resp handshake, unchanged when both coincide.

Reset
REQ-030 While rst_n=0 at a clock edge: all slot valid bits, resp_valid, div_in_valid cleared; resp_data=0, resp_tag=0, inflight_cnt=0; idle=1.
REQ-031 Reset mid-operation SHALL discard all in-flight work; no stale response after rst_n returns high.

Verification
REQ-032 DIVU 100/7, tag 3, resp_ready=1 -> resp_data=14, resp_tag=3 exactly 29 cycles after accept.
REQ-033 REM -7 % 2 (0xFFFFFFF9, 2) -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD.
REQ-034 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-035 30 back-to-back requests tags 0..29, resp_ready low for 10 cycles after first response -> all 30 returned in tag order, none lost or duplicated, req_ready low while held.
REQ-036 flush 10 cycles after 5 accepts -> no responses, inflight_cnt=0, next request returns correctly.
REQ-037 rst_n low for 1 cycle with 8 in flight -> outputs at reset values, no response emitted afterward.

Source files
------------

// File: rtl/div_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : div_sched_if                                                    |
// | Brief    : Request/response handshake bundle for the divide scheduler.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface div_sched_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : div_sched                                                       |
// | Brief    : Signed/unsigned divide front-end around a pipelined unsigned    |
// |            divider core, with in-order tagged responses and flush.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module div_sched #(
    parameter int LATENCY = 28,
    parameter int TAG_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    div_sched_if.slave  bus,
    input  logic        flush,
    output logic        div_in_valid,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic [1:0]  div_ctrl,
    output logic        div_stall,
    input  logic [31:0] div_ans,
    input  logic        div_out_valid,
    output logic [5:0]  inflight_cnt,
    output logic        idle
);
    localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             neg;
        logic             spec;
        logic [31:0]      spec_val;
    } meta_t;

    logic             w_stall;
    logic             w_req_ready;
    logic             w_accept;
    logic             w_resp_hs;
    logic             w_load;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_ovf;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_result;
    meta_t            w_meta;

    logic             r_in_valid;
    logic [31:0]      r_dividend;
    logic [31:0]      r_divisor;
    logic [1:0]       r_ctrl;
    meta_t            r_in_meta;
    logic [LATENCY-1:0] r_slot_vld;
    meta_t            r_slot [LATENCY];
    logic             r_resp_valid;
    logic [31:0]      r_resp_data;
    logic [TAG_W-1:0] r_resp_tag;
    logic [5:0]       r_cnt;

    always_comb begin
        w_stall     = r_resp_valid & ~bus.resp_ready;
        w_req_ready = ~w_stall & ~flush;
        w_accept    = bus.req_valid & w_req_ready;
        w_resp_hs   = r_resp_valid & bus.resp_ready;

        w_signed = ~bus.req_op[0];
        w_a_neg  = w_signed & bus.req_a[31];
        w_b_neg  = w_signed & bus.req_b[31];
        w_a_mag  = w_a_neg ? (32'd0 - bus.req_a) : bus.req_a;
        w_b_mag  = w_b_neg ? (32'd0 - bus.req_b) : bus.req_b;
        w_b_zero = (bus.req_b == 32'd0);
        w_ovf    = w_signed & (bus.req_a == c_INT_MIN) & (bus.req_b == c_ALL_ONES);

        // Remainder takes the dividend's sign; quotient the XOR of signs.
        w_meta      = '0;
        w_meta.tag  = bus.req_tag;
        w_meta.neg  = bus.req_op[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & ~w_b_zero);
        w_meta.spec = w_b_zero | w_ovf;
        if (w_b_zero) begin
            w_meta.spec_val = bus.req_op[1] ? bus.req_a : c_ALL_ONES;
        end else begin
            w_meta.spec_val = bus.req_op[1] ? 32'd0 : c_INT_MIN;
        end

        w_load   = r_slot_vld[0] & div_out_valid & ~w_stall;
        w_result = div_ans;
        if (r_slot[0].spec) begin
            w_result = r_slot[0].spec_val;
        end else if (r_slot[0].neg) begin
            w_result = 32'd0 - div_ans;
        end
    end

    // Core input register; it and the core freeze together on stall.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_in_valid <= 1'b0;
        end else if (!w_stall) begin
            r_in_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall && w_accept) begin
            r_dividend <= w_a_mag;
            r_divisor  <= w_b_mag;
            r_ctrl     <= {bus.req_op[1], 1'b1};
            r_in_meta  <= w_meta;
        end
    end

    // Metadata enters at the top slot in step with the core sampling its input.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_slot_vld <= '0;
        end else if (!w_stall) begin
            r_slot_vld[LATENCY-1] <= r_in_valid;
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_slot_vld[i] <= r_slot_vld[i+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_slot[LATENCY-1] <= r_in_meta;
            for (int i = 0; i < LATENCY - 1; i++) begin
                r_slot[i] <= r_slot[i+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_tag   <= '0;
        end else if (flush) begin
            r_resp_valid <= 1'b0;
        end else if (w_load) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_result;
            r_resp_tag   <= r_slot[0].tag;
        end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_cnt <= 6'd0;
        end else if (w_accept && !w_resp_hs) begin
            r_cnt <= r_cnt + 6'd1;
        end else if (!w_accept && w_resp_hs) begin
            r_cnt <= r_cnt - 6'd1;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_resp_tag;
    assign div_in_valid   = r_in_valid;
    assign div_dividend   = r_dividend;
    assign div_divisor    = r_divisor;
    assign div_ctrl       = r_ctrl;
    assign div_stall      = w_stall;
    assign inflight_cnt   = r_cnt;
    assign idle           = (r_cnt == 6'd0);
endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_div_sched                                                    |
// | Brief    : Scoreboard bench for div_sched with a behavioural divider core. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_div_sched;
    localparam int LAT = 28;
    localparam int TW  = 5;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        div_in_valid;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [1:0]  div_ctrl;
    logic        div_stall;
    logic [31:0] div_ans;
    logic        div_out_valid;
    logic [5:0]  inflight_cnt;
    logic        idle;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_resp   = 0;
    int   cyc      = 0;
    int   m_cnt    = 0;
    int   rr_mode  = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];
    logic [32:0] core_pipe [LAT];

    div_sched_if #(.TAG_W(TW)) bus ();

    div_sched #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flush        (flush),
        .div_in_valid (div_in_valid),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_ctrl     (div_ctrl),
        .div_stall    (div_stall),
        .div_ans      (div_ans),
        .div_out_valid(div_out_valid),
        .inflight_cnt (inflight_cnt),
        .idle         (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unsigned divider core: poisoned outputs expose misuse of ctrl or b==0.
    function automatic logic [31:0] core_fn(logic [31:0] x, logic [31:0] y, logic [1:0] ctrl);
        if (!ctrl[0]) return 32'hBAD0_BAD0;
        if (y == 32'd0) return 32'hDEAD_BEEF;
        return ctrl[1] ? (x % y) : (x / y);
    endfunction

    always @(posedge clk) begin
        if (!div_stall) begin
            for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
            core_pipe[0] <= {div_in_valid, core_fn(div_dividend, div_divisor, div_ctrl)};
        end
    end
    assign div_out_valid = core_pipe[LAT-1][32];
    assign div_ans       = core_pipe[LAT-1][31:0];

    // RISC-V M-extension semantics via 64-bit arithmetic (truncating division).
    function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TW-1:0] tag, input bit chk_lat,
                            input bit use_exp, input logic [31:0] exp_val);
        bit acc = 1'b0;
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        while (!acc && waited <= 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        bus.req_valid = 1'b0;
        check("req_accept_timeout", acc, 1'b1);
        if (acc) exp_q.push_back('{tag, use_exp ? exp_val : ref_div(op, a, b), cyc, chk_lat});
    endtask

    task automatic drain(string name);
        int k = 0;
        while ((exp_q.size() != 0 || bus.resp_valid) && k < 1000) begin
            cycles(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_resp_tag", bus.resp_tag, '0);
        check("rst_inflight", inflight_cnt, 6'd0);
        check("rst_idle", idle, 1'b1);
        check("rst_div_in_valid", div_in_valid, 1'b0);
    endtask

    task automatic b2b_requests();
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  op = 2'($urandom_range(0, 3));
            logic [31:0] a  = rand_operand();
            logic [31:0] b  = rand_operand();
            send_req(op, a, b, TW'(t), 1'b0, 1'b0, 32'd0);
        end
    endtask

    task automatic hold_window();
        int k = 0;
        while (!bus.resp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_resp", bus.resp_valid, 1'b1);
        @(posedge clk);
        #1;
        rr_mode = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("req_ready_while_held", bus.req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rr_mode = 0;
    endtask

    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       bus.resp_ready = 1'b1;
                1:       bus.resp_ready = ($urandom_range(0, 3) != 0);
                default: bus.resp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop, hold stability and in-flight occupancy.
    initial begin
        exp_t        e;
        bit          hold_pend = 1'b0;
        logic [31:0] hold_data = '0;
        logic [TW-1:0] hold_tag = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("inflight_cnt", inflight_cnt, m_cnt);
                check("idle", idle, m_cnt == 0);
                if (hold_pend && bus.resp_valid) begin
                    check("hold_data", bus.resp_data, hold_data);
                    check("hold_tag", bus.resp_tag, hold_tag);
                end
                if (bus.resp_valid && bus.resp_ready) begin
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        check("resp_while_none_expected", bus.resp_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_tag", bus.resp_tag, e.tag);
                        check("resp_data", bus.resp_data, e.data);
                        if (e.chk_lat) check("latency", cyc - e.acc_cyc, LAT + 1);
                    end
                end
                hold_pend = bus.resp_valid && !bus.resp_ready;
                hold_data = bus.resp_data;
                hold_tag  = bus.resp_tag;
                if (!rst_n || flush) m_cnt = 0;
                else m_cnt = m_cnt + int'(bus.req_valid && bus.req_ready)
                                   - int'(bus.resp_valid && bus.resp_ready);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_tag   = '0;
        cycles(3);
        check_reset_vals();
        mon_en = 1'b1;
        cycles(1);
        rst_n = 1'b1;
        cycles(2);

        // Directed: DIVU 100/7, signed rounding, divide-by-zero, overflow.
        send_req(2'b01, 32'd100, 32'd7, TW'(3), 1'b1, 1'b1, 32'd14);
        send_req(2'b10, 32'hFFFF_FFF9, 32'd2, TW'(4), 1'b1, 1'b1, 32'hFFFF_FFFF);
        send_req(2'b00, 32'hFFFF_FFF9, 32'd2, TW'(5), 1'b1, 1'b1, 32'hFFFF_FFFD);
        send_req(2'b00, 32'd5, 32'd0, TW'(6), 1'b1, 1'b1, 32'hFFFF_FFFF);
        send_req(2'b10, 32'd5, 32'd0, TW'(7), 1'b1, 1'b1, 32'd5);
        send_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, TW'(8), 1'b1, 1'b1, 32'h8000_0000);
        send_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, TW'(9), 1'b1, 1'b1, 32'd0);
        send_req(2'b11, 32'd100, 32'd7, TW'(10), 1'b1, 1'b1, 32'd2);
        drain("directed_drain");

        // Back-to-back with a 10-cycle response hold.
        r0 = n_resp;
        fork
            b2b_requests();
            hold_window();
        join
        drain("b2b_drain");
        check("b2b_resp_count", n_resp - r0, 30);

        // Flush with work in flight; an offered request must not be taken.
        for (int i = 0; i < 5; i++) send_req(2'b01, 32'd50 + 32'(i), 32'd3, TW'(i), 1'b0, 1'b0, 32'd0);
        cycles(10);
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_tag   = TW'(31);
        @(negedge clk);
        check("req_ready_during_flush", bus.req_ready, 1'b0);
        cycles(1);
        flush = 1'b0;
        bus.req_valid = 1'b0;
        exp_q.delete();
        check("flush_inflight", inflight_cnt, 6'd0);
        check("flush_resp_valid", bus.resp_valid, 1'b0);
        cycles(60);
        r0 = n_resp;
        send_req(2'b00, 32'hFFFF_FF9C, 32'd7, TW'(12), 1'b1, 1'b1, 32'hFFFF_FFF2);
        drain("post_flush_drain");
        check("post_flush_resp_count", n_resp - r0, 1);

        // Reset with eight requests in flight.
        for (int i = 0; i < 8; i++) send_req(2'b11, 32'd90 + 32'(i), 32'd4, TW'(i), 1'b0, 1'b0, 32'd0);
        cycles(3);
        rst_n = 1'b0;
        cycles(1);
        check_reset_vals();
        rst_n = 1'b1;
        exp_q.delete();
        cycles(60);
        send_req(2'b10, 32'd17, 32'd5, TW'(21), 1'b1, 1'b1, 32'd2);
        drain("post_reset_drain");

        // Randomized traffic with random response back-pressure.
        rr_mode = 1;
        for (int t = 0; t < 300; t++) begin
            logic [1:0]  op = 2'($urandom_range(0, 3));
            logic [31:0] a  = rand_operand();
            logic [31:0] b  = rand_operand();
            send_req(op, a, b, TW'(t), 1'b0, 1'b0, 32'd0);
            cycles($urandom_range(0, 2));
        end
        rr_mode = 0;
        drain("random_drain");
        cycles(2);
        check("final_idle", idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
